// File: rtl/sync_to_ncl_encoder.sv
// sync_to_ncl_encoder: buffers binary words in a FIFO and presents them as NCL wavefronts
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready  : producer handshake for in_data (binary word)
//   ki                  : asynchronous receiver completion, 1 = request DATA, 0 = request NULL
//   out_rails           : registered NCL wavefront (dual-rail MODE=0, quad-rail MODE=1)
//   fifo_count, tok_cnt : FIFO occupancy, count of completed DATA wavefronts (wrapping)
module sync_to_ncl_encoder #(
   parameter int WIDTH = 8,
   parameter int MODE = 0,
   parameter int DEPTH = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_data,
   input  logic                    ki,
   output logic [2*WIDTH-1:0]      out_rails,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic [15:0]             tok_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];
   typedef enum logic {S_NULL, S_DATA} state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0] ki_sync;
   logic ki_s, push, load, pop;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [WIDTH-1:0] head;
   logic [2*WIDTH-1:0] enc;
   assign ki_s = ki_sync[SYNC_STAGES-1];
   assign in_ready = fifo_count < FULL;
   assign push = in_valid && in_ready;
   assign head = mem[rp];
   generate
      if (MODE == 0) begin : g_dual
         for (genvar g = 0; g < WIDTH; g++) begin : g_bit
            assign enc[2*g +: 2] = head[g] ? 2'b10 : 2'b01;
         end
      end else begin : g_quad
         for (genvar g = 0; g < WIDTH/2; g++) begin : g_pair
            assign enc[4*g +: 4] = 4'b0001 << head[2*g +: 2];
         end
      end
   endgenerate
   // ki is only ever observed through this synchronizer
   always_ff @(posedge clk or posedge rst)
      if (rst) ki_sync <= '0;
      else ki_sync <= {ki_sync[SYNC_STAGES-2:0], ki};
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_NULL;
      else state <= state_n;
   always_comb begin
      state_n = state;
      load = 1'b0;
      pop = 1'b0;
      if (state == S_NULL && ki_s && fifo_count != '0) begin
         state_n = S_DATA;
         load = 1'b1;
      end
      if (state == S_DATA && !ki_s) begin
         state_n = S_NULL;
         pop = 1'b1;
      end
   end
   // head is popped only when its DATA wavefront is acknowledged, so it stays fixed during S_DATA
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_rails <= '0;
         fifo_count <= '0;
         tok_cnt <= '0;
         wp <= '0;
         rp <= '0;
      end else begin
         if (load) out_rails <= enc;
         else if (pop) out_rails <= '0;
         if (push) wp <= wp + 1'b1;
         if (pop) begin
            rp <= rp + 1'b1;
            tok_cnt <= tok_cnt + 16'd1;
         end
         fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   always_ff @(posedge clk)
      if (push) mem[wp] <= in_data;
endmodule
